mips_bus_mem_responder: RTL and testbench

//  Synthesizable responder (memory) end of the CPU data/instruction bus driven by mips_cpu_bus.

---
 rtl/mips_bus_mem_responder_if.sv | 21 ++
 rtl/mips_bus_mem_responder.sv | 139 +++++++++++++
 tb/tb_mips_bus_mem_responder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mips_bus_mem_responder_if.sv
// CPU-side memory bus bundle: request/handshake from mips_cpu_bus, responses from the memory.
interface mips_bus_mem_responder_if;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        err;

    modport master (
        output address, write, read, writedata, byteenable,
        input  waitrequest, readdata, err
    );

    modport slave (
        input  address, write, read, writedata, byteenable,
        output waitrequest, readdata, err
    );
endinterface

// File: rtl/mips_bus_mem_responder.sv
// Word-addressed RAM responder for the mips_cpu_bus memory interface, with programmable
// wait states, byte-lane write masking, registered read data and a sticky error flag.
module mips_bus_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter              INIT_FILE   = ""
) (
    input logic                      clk,
    input logic                      reset,
    mips_bus_mem_responder_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LAST = 4'((WAIT_CYCLES >= 2) ? (WAIT_CYCLES - 2) : 0);

    if (DEPTH_WORDS < 4 || DEPTH_WORDS > 4096 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("DEPTH_WORDS must be a power of two in 4..4096");
    end
    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 0..15");
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
        $error("BASE_ADDR must be word aligned");
    end
    if (INIT_FILE != "") begin : g_init_note
        $info("INIT_FILE image is not loaded by this RAM; preload through bus writes");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCEPT
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH_WORDS];

    logic          req;
    logic          ready;
    logic          accept;
    logic          both;
    logic [29:0]   offset_w;
    logic          in_range;
    logic          aligned;
    logic          hit;
    logic [AW-1:0] idx;
    logic [3:0]    lanes;
    logic          mem_we;

    // Word offset is taken on address[31:2]; with an aligned base this equals the
    // byte difference >> 2 under mod-2^32 wrap, so below-base addresses land out of range.
    always_comb begin
        req      = bus.read | bus.write;
        ready    = (state == S_ACCEPT) || (state == S_IDLE && WAIT_CYCLES == 0);
        accept   = req & ready & reset;
        both     = bus.read & bus.write;
        offset_w = bus.address[31:2] - BASE_ADDR[31:2];
        in_range = (offset_w[29:AW] == '0);
        aligned  = (bus.address[1:0] == 2'b00);
        hit      = in_range & aligned;
        idx      = offset_w[AW-1:0];
        lanes    = (bus.byteenable == 4'b0000) ? 4'b1111 : bus.byteenable;
        mem_we   = accept & bus.write & ~bus.read & hit;
    end

    assign bus.waitrequest = req & ~ready & reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lanes[i]) begin
                    mem[idx][8*i +: 8] <= bus.writedata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bus.readdata <= '0;
            bus.err      <= 1'b0;
        end else begin
            if (accept) begin
                if (both) begin
                    bus.err <= 1'b1;
                end else if (bus.read) begin
                    if (bus.address == 32'h0000_0000) begin
                        bus.readdata <= '0;
                    end else if (!hit) begin
                        bus.readdata <= '0;
                        bus.err      <= 1'b1;
                    end else begin
                        bus.readdata <= mem[idx];
                    end
                end else if (!hit) begin
                    bus.err <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (req && WAIT_CYCLES != 0) begin
                        state <= (WAIT_CYCLES == 1) ? S_ACCEPT : S_WAIT;
                        cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state   <= S_IDLE;
                        cnt     <= '0;
                        bus.err <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_ACCEPT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_ACCEPT: begin
                    // Request vanished in the cycle it would have been taken: abandon it.
                    if (!req) begin
                        bus.err <= 1'b1;
                    end
                    state <= S_IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_bus_mem_responder.sv
// Directed bench for mips_bus_mem_responder at WAIT_CYCLES = 0, 2 and 3.
module tb_mips_bus_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_bus_mem_responder_if bus0 ();
    mips_bus_mem_responder_if bus2 ();
    mips_bus_mem_responder_if bus3 ();

    mips_bus_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (.clk(clk), .reset(rst_n), .bus(bus0));
    mips_bus_mem_responder #(.WAIT_CYCLES(2)) u_dut2 (.clk(clk), .reset(rst_n), .bus(bus2));
    mips_bus_mem_responder #(.WAIT_CYCLES(3)) u_dut3 (.clk(clk), .reset(rst_n), .bus(bus3));

    // sel: 0 -> W=0 instance, 1 -> W=2 instance, 2 -> W=3 instance
    int          sel = 1;
    logic [31:0] a = '0;
    logic [31:0] d = '0;
    logic [3:0]  be = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;

    assign bus0.address = a;  assign bus0.writedata = d;  assign bus0.byteenable = be;
    assign bus2.address = a;  assign bus2.writedata = d;  assign bus2.byteenable = be;
    assign bus3.address = a;  assign bus3.writedata = d;  assign bus3.byteenable = be;
    assign bus0.read = rd & (sel == 0);  assign bus0.write = wr & (sel == 0);
    assign bus2.read = rd & (sel == 1);  assign bus2.write = wr & (sel == 1);
    assign bus3.read = rd & (sel == 2);  assign bus3.write = wr & (sel == 2);

    logic        wreq;
    logic        errv;
    logic [31:0] rdata;
    always_comb begin
        wreq  = bus0.waitrequest;
        errv  = bus0.err;
        rdata = bus0.readdata;
        if (sel == 1) begin
            wreq = bus2.waitrequest; errv = bus2.err; rdata = bus2.readdata;
        end else if (sel == 2) begin
            wreq = bus3.waitrequest; errv = bus3.err; rdata = bus3.readdata;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One transfer with waitrequest timing checked; returns at the negedge after acceptance.
    task automatic xfer(input int s, input bit is_rd, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] bes);
        int w;
        w = (s == 0) ? 0 : ((s == 1) ? 2 : 3);
        @(posedge clk); #1;
        sel = s; a = addr; d = data; be = bes; rd = is_rd; wr = ~is_rd;
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            check("wait_hi", {31'b0, wreq}, 32'd1);
        end
        @(negedge clk);
        check("wait_lo", {31'b0, wreq}, 32'd0);
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [5:0] pat;
        pat = 6'b011011;

        // Reset state, with a request pending to show waitrequest is held low in reset
        sel = 1; a = 32'hBFC00004; rd = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_wait", {31'b0, wreq}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_err", {31'b0, errv}, 32'd0);
        rd = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;

        // W=2: preload and timed read
        xfer(1, 0, 32'hBFC00004, 32'h8D090030, 4'hF);
        xfer(1, 0, 32'hBFC00000, 32'h13579BDF, 4'hF);
        xfer(1, 1, 32'hBFC00004, '0, 4'h0);
        check("w2_read", rdata, 32'h8D090030);
        check("w2_err0", {31'b0, errv}, 32'd0);

        // byteenable 0000 behaves as full word
        xfer(1, 0, 32'hBFC00030, 32'hFFFF0000, 4'h0);
        xfer(1, 1, 32'hBFC00030, '0, 4'h0);
        check("be0_read", rdata, 32'hFFFF0000);
        check("be0_err", {31'b0, errv}, 32'd0);

        // single-lane merge
        xfer(1, 0, 32'hBFC00008, 32'h11223344, 4'hF);
        xfer(1, 0, 32'hBFC00008, 32'hAABBCCDD, 4'b0010);
        xfer(1, 1, 32'hBFC00008, '0, 4'h0);
        check("lane1_read", rdata, 32'h1122CC44);

        // address changed during wait states: acceptance-edge address wins
        @(posedge clk); #1; sel = 1; a = 32'hBFC00030; rd = 1'b1;
        @(posedge clk); #1; a = 32'hBFC00004;
        @(posedge clk); #1;
        @(posedge clk); #1; rd = 1'b0;
        @(negedge clk);
        check("addr_change", rdata, 32'h8D090030);

        // held request: every transfer pays the full wait
        @(posedge clk); #1; sel = 1; a = 32'hBFC00030; rd = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("b2b_wait", {31'b0, wreq}, {31'b0, pat[i]});
        end
        @(posedge clk); #1; rd = 1'b0;
        @(negedge clk);
        check("b2b_read", rdata, 32'hFFFF0000);

        // idle-address read
        xfer(1, 1, 32'h00000000, '0, 4'h0);
        check("addr0_read", rdata, 32'h0);
        check("addr0_err", {31'b0, errv}, 32'd0);

        // misaligned and out-of-range
        xfer(1, 1, 32'hBFC00004, '0, 4'h0);
        xfer(1, 1, 32'hBFC00402, '0, 4'h0);
        check("misalign_read", rdata, 32'h0);
        check("misalign_err", {31'b0, errv}, 32'd1);
        xfer(1, 1, 32'hBFC00004, '0, 4'h0);
        check("restore_read", rdata, 32'h8D090030);
        xfer(1, 1, 32'hC0000000, '0, 4'h0);
        check("oor_read", rdata, 32'h0);
        xfer(1, 0, 32'hBFC00400, 32'hDEADBEEF, 4'hF);
        xfer(1, 1, 32'hBFC00000, '0, 4'h0);
        check("oor_no_alias", rdata, 32'h13579BDF);

        // W=0: lane write onto zero, then read+write collision
        sel = 0;
        @(negedge clk);
        check("w0_err_init", {31'b0, errv}, 32'd0);
        xfer(0, 0, 32'hBFC00010, 32'h00000000, 4'hF);
        xfer(0, 0, 32'hBFC00010, 32'hAABBCCDD, 4'b0100);
        xfer(0, 1, 32'hBFC00010, '0, 4'h0);
        check("w0_read", rdata, 32'h00BB0000);
        check("w0_err0", {31'b0, errv}, 32'd0);
        @(posedge clk); #1; sel = 0; a = 32'hBFC00010; d = 32'hFFFFFFFF; be = 4'hF; rd = 1'b1; wr = 1'b1;
        @(negedge clk);
        check("both_wait", {31'b0, wreq}, 32'd0);
        @(posedge clk); #1; rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        check("both_err", {31'b0, errv}, 32'd1);
        check("both_rdata", rdata, 32'h00BB0000);
        xfer(0, 1, 32'hBFC00010, '0, 4'h0);
        check("both_nowrite", rdata, 32'h00BB0000);

        // W=3: timed transfer, dropped request, mid-transfer reset
        xfer(2, 0, 32'hBFC00008, 32'hCAFEF00D, 4'hF);
        xfer(2, 1, 32'hBFC00008, '0, 4'h0);
        check("w3_read", rdata, 32'hCAFEF00D);
        check("w3_err0", {31'b0, errv}, 32'd0);
        @(posedge clk); #1; sel = 2; a = 32'hBFC00004; rd = 1'b1;
        @(negedge clk);
        check("drop_wait", {31'b0, wreq}, 32'd1);
        @(posedge clk); #1; rd = 1'b0;
        repeat (4) @(negedge clk);
        check("drop_rdata", rdata, 32'hCAFEF00D);
        check("drop_err", {31'b0, errv}, 32'd1);
        xfer(2, 1, 32'hBFC00008, '0, 4'h0);
        check("after_drop", rdata, 32'hCAFEF00D);

        @(posedge clk); #1; sel = 2; a = 32'hBFC00008; d = 32'h12345678; be = 4'hF; wr = 1'b1;
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_err", {31'b0, errv}, 32'd0);
        check("mid_rst_rdata", rdata, 32'h0);
        check("mid_rst_wait", {31'b0, wreq}, 32'd0);
        @(posedge clk); #1; wr = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        xfer(2, 1, 32'hBFC00008, '0, 4'h0);
        check("mid_rst_nowrite", rdata, 32'hCAFEF00D);
        xfer(1, 1, 32'hBFC00004, '0, 4'h0);
        check("mem_kept", rdata, 32'h8D090030);
        check("post_rst_err", {31'b0, errv}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
